// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter / interval timer.
// Counts a loaded value down to zero, emits a one-cycle terminal-count pulse,
// and optionally reloads itself to repeat the interval.
//
// Ports:
//   clk    in   system clock, all state changes on its rising edge
//   reset  in   synchronous active-high reset
//   En     in   count enable
//   load   in   synchronous load strobe
//   load2  in   [WIDTH-1:0] value captured on load
//   auto   in   1 = reload at terminal count, 0 = one-shot
//   q      out  [WIDTH-1:0] current count (registered)
//   tc     out  terminal-count pulse, one cycle (registered)
//   busy   out  high while RUN or PAUSE
//   state  out  [1:0] FSM state: IDLE=00 RUN=01 PAUSE=10 DONE=11
module countdown_timer #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic             load,
  input  logic [WIDTH-1:0] load2,
  input  logic             auto,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      // A zero load parks the timer; any other value (re)starts it without a pulse.
      q_d      = load2;
      reload_d = load2;
      if (load2 == '0) state_d = IDLE;
      else             state_d = En ? RUN : PAUSE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN, PAUSE: begin
          if (!En) begin
            state_d = PAUSE;
          end else if (q_q == WIDTH'(1)) begin
            tc_d = 1'b1;
            if (auto) begin
              q_d     = reload_q;
              state_d = RUN;
            end else begin
              q_d     = '0;
              state_d = DONE;
            end
          end else begin
            // q is never 0 in RUN/PAUSE, so this cannot wrap.
            q_d     = q_q - WIDTH'(1);
            state_d = RUN;
          end
        end
        DONE: begin
          q_d     = '0;
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign q     = q_q;
  assign tc    = tc_q;
  assign state = state_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSE);

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer.
// Each check compares the packed observation {q, tc, busy, state}.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        En = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load2 = '0;
  logic        auto = 1'b0;
  logic [11:0] q;
  logic        tc;
  logic        busy;
  logic [1:0]  state;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  countdown_timer #(.WIDTH(12)) dut (
    .clk   (clk),
    .reset (reset),
    .En    (En),
    .load  (load),
    .load2 (load2),
    .auto  (auto),
    .q     (q),
    .tc    (tc),
    .busy  (busy),
    .state (state)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    reset = 1'b1; En = 1'b0; load = 1'b0;
    step();
    exp = {12'h000, 1'b0, 1'b0, 2'b00};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL reset: got %h want %h", {q, tc, busy, state}, exp);
    end
    reset = 1'b0; En = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({q, tc, busy, state} !== exp) begin
        errors++;
        $display("FAIL idle[%0d]: got %h want %h", i, {q, tc, busy, state}, exp);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [15:0] exp;
    auto = 1'b0; load = 1'b1; load2 = 12'h012; En = 1'b1;
    step();
    exp = {12'h012, 1'b0, 1'b1, 2'b01};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL oneshot_load: got %h want %h", {q, tc, busy, state}, exp);
    end
    load = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      step();
      if (i == 18) exp = {12'h000, 1'b1, 1'b0, 2'b11};
      else         exp = {12'h012 - 12'(i), 1'b0, 1'b1, 2'b01};
      vectors++;
      if ({q, tc, busy, state} !== exp) begin
        errors++;
        $display("FAIL oneshot_dec[%0d]: got %h want %h", i, {q, tc, busy, state}, exp);
      end
    end
    exp = {12'h000, 1'b0, 1'b0, 2'b11};
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({q, tc, busy, state} !== exp) begin
        errors++;
        $display("FAIL done_hold[%0d]: got %h want %h", i, {q, tc, busy, state}, exp);
      end
    end
    // Loading from DONE with En=0 lands in PAUSE.
    load = 1'b1; load2 = 12'h004; En = 1'b0;
    step();
    load = 1'b0;
    exp = {12'h004, 1'b0, 1'b1, 2'b10};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL done_load_pause: got %h want %h", {q, tc, busy, state}, exp);
    end
  endtask

  task automatic test_pause_resume();
    logic [15:0] exp;
    load = 1'b1; load2 = 12'h00C; En = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) step();
    exp = {12'h009, 1'b0, 1'b1, 2'b01};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL pause_pre: got %h want %h", {q, tc, busy, state}, exp);
    end
    En = 1'b0;
    exp = {12'h009, 1'b0, 1'b1, 2'b10};
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if ({q, tc, busy, state} !== exp) begin
        errors++;
        $display("FAIL pause_hold[%0d]: got %h want %h", i, {q, tc, busy, state}, exp);
      end
    end
    En = 1'b1;
    step();
    exp = {12'h008, 1'b0, 1'b1, 2'b01};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL resume: got %h want %h", {q, tc, busy, state}, exp);
    end
  endtask

  task automatic test_auto_reload();
    logic [15:0] exp;
    logic [11:0] seq [6] = '{12'h002, 12'h001, 12'h003, 12'h002, 12'h001, 12'h003};
    auto = 1'b1; load = 1'b1; load2 = 12'h003; En = 1'b1;
    step();
    load = 1'b0;
    exp = {12'h003, 1'b0, 1'b1, 2'b01};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL auto_load: got %h want %h", {q, tc, busy, state}, exp);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      exp = {seq[i], (seq[i] == 12'h003), 1'b1, 2'b01};
      vectors++;
      if ({q, tc, busy, state} !== exp) begin
        errors++;
        $display("FAIL auto_seq[%0d]: got %h want %h", i, {q, tc, busy, state}, exp);
      end
    end
    auto = 1'b0;
  endtask

  task automatic test_mid_load();
    logic [15:0] exp;
    load = 1'b1; load2 = 12'h008; En = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) step();
    exp = {12'h005, 1'b0, 1'b1, 2'b01};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL midload_pre: got %h want %h", {q, tc, busy, state}, exp);
    end
    load = 1'b1; load2 = 12'h00A;
    step();
    load = 1'b0;
    exp = {12'h00A, 1'b0, 1'b1, 2'b01};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL midload_reload: got %h want %h", {q, tc, busy, state}, exp);
    end
    step();
    exp = {12'h009, 1'b0, 1'b1, 2'b01};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL midload_continue: got %h want %h", {q, tc, busy, state}, exp);
    end
    load = 1'b1; load2 = 12'h000;
    step();
    load = 1'b0;
    exp = {12'h000, 1'b0, 1'b0, 2'b00};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL zero_load: got %h want %h", {q, tc, busy, state}, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    // Load on the terminal edge wins over the tc.
    load = 1'b1; load2 = 12'h002; En = 1'b1;
    step();
    load = 1'b0;
    step();
    exp = {12'h001, 1'b0, 1'b1, 2'b01};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL b2b_pre: got %h want %h", {q, tc, busy, state}, exp);
    end
    load = 1'b1; load2 = 12'h005;
    step();
    load = 1'b0;
    exp = {12'h005, 1'b0, 1'b1, 2'b01};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL b2b_load_wins: got %h want %h", {q, tc, busy, state}, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    load = 1'b1; load2 = 12'h002; En = 1'b1;
    step();
    load = 1'b0;
    step();
    reset = 1'b1;
    step();
    exp = {12'h000, 1'b0, 1'b0, 2'b00};
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL reset_mid: got %h want %h", {q, tc, busy, state}, exp);
    end
    reset = 1'b0;
    step();
    vectors++;
    if ({q, tc, busy, state} !== exp) begin
      errors++;
      $display("FAIL reset_after: got %h want %h", {q, tc, busy, state}, exp);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_pause_resume();
    test_auto_reload();
    test_mid_load();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- 12-bit loadable down-counter/timer; the counting-down counterpart of the lab's up-counter (`contador`).
- Shares that block's control interface: `En`, `load`, `load2`, `q`.
- Counts a loaded value down to zero, flags terminal count and optionally auto-reloads.
- Used as an interval/delay timer next to the program-counter path in the lab datapath.

Parameters:
- WIDTH, 12, bit width of the count, reload register and load value.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- En  in  1  count enable; decrement permitted when 1.
- load  in  1  synchronous load strobe.
- load2  in  WIDTH  value captured on load.
- auto  in  1  1 = auto-reload at terminal count, 0 = one-shot.
- q  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse, one cycle wide (registered).
- busy  out  1  1 while in RUN or PAUSE.
- state  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Reset (synchronous, active-high):
  - On an edge with reset=1: q=0, reload register=0, tc=0, state=IDLE, busy=0.
  - Reset mid-count aborts immediately and does not produce a tc pulse.
- Priority per edge: reset > load > count.
- tc defaults to 0 on every edge; it is set only as described below.
- busy is derived combinationally from the state register: busy = (state==RUN || state==PAUSE).
- Load, load=1, load2!=0:
  - q<=load2 and reload<=load2.
  - state<=RUN if En=1, else PAUSE.
  - No decrement on the load edge; the first decrement happens on the next edge with En=1.
  - Legal in any state; mid-count it restarts the count with no tc.
- Load, load=1, load2==0: q<=0, reload<=0, state<=IDLE, no tc.
- IDLE: q holds; En is ignored; leaves only on load.
- RUN / PAUSE (no load), En=1:
  - If q>1: q<=q-1, state<=RUN.
  - If q==1 and auto=1: q<=reload, tc<=1, state<=RUN. The count period is reload edges.
  - If q==1 and auto=0: q<=0, tc<=1, state<=DONE.
- RUN / PAUSE (no load), En=0: q holds, state<=PAUSE. Resuming needs no extra cycle.
- DONE: q=0; En and auto are ignored; leaves only on load or reset.
- Arithmetic: unsigned. The decrement never wraps, because q==0 is never decremented (0 occurs only in IDLE/DONE).
- Latency: the tc pulse is visible in the same cycle q shows 0 (one-shot) or shows the reload value (auto).
- Simultaneous events:
  - load=1 with En=1 on the terminal edge: the load wins, no tc.
  - auto changed mid-count: only its value on the q==1 edge matters.
- Illegal state encodings are not possible with this encoding; any unreachable value recovers to IDLE on the next edge.

Test Plan:
- Reset then idle: reset=1 for 1 edge, then En=1, load=0 for 5 edges -> q=0x000, state=00, tc=0, busy=0 throughout.
- One-shot: load=1, load2=0x012, En=1 for 1 edge, then load=0, En=1 ->
  - q=0x012, then 0x011 ... 0x001, then 0x000 on the 18th decrement edge;
  - tc=1 for exactly that cycle, state=11, q stays 0 with En=1.
- Pause/resume: load 0x00C, decrement 3 edges (q=0x009), En=0 for 4 edges ->
  - q stays 0x009, state=10, busy=1;
  - with En=1 again, next edge gives q=0x008, state=01.
- Auto-reload: auto=1, load 0x003, En=1 -> q sequence 3,2,1,3,2,1,3; tc=1 on each cycle q returns to 3 (every 3 edges); state stays 01.
- Mid-count reload and zero load:
  - At q=0x005, load 0x00A -> q=0x00A, no tc, count continues.
  - Then load 0x000 -> q=0, state=00, no tc.
- Reset mid-operation: at q=0x001 with En=1, assert reset -> q=0, state=00, tc=0 (no terminal pulse).
